multi_digit_led_driver: RTL

Parametrised time-multiplexed driver for common-anode seven-segment displays, the next generation of the four-digit scan driver. It scans NUM_DIGITS digits from a per-digit hex bus with per-digit decimal point and enable, and takes frame-coherent snapshots through a load/ack handshake. A prescaler replaces the DCM-divided scan clock, so the whole block runs on the board clock. It sits between user logic and the board's anode, segment and dp pins.

---
 rtl/led_pkg.sv | 19 +
 rtl/led_hex_decoder.sv | 11 +
 rtl/multi_digit_led_driver.sv | 122 ++++++++++++
 3 files changed

// File: rtl/led_pkg.sv
// Shared constants for the seven-segment display blocks:
// blank pattern, hex glyph table and counter width helper.
package led_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h01, 7'h4F, 7'h12, 7'h06,
        7'h4C, 7'h24, 7'h20, 7'h0F,
        7'h00, 7'h04, 7'h08, 7'h60,
        7'h31, 7'h42, 7'h30, 7'h38
    };

    // Width of a counter that runs 0..n-1 (never below one bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/led_hex_decoder.sv
// Hex nibble to active-low seven-segment pattern, a..g on bits 6..0.
module led_hex_decoder
    import led_pkg::*;
(
    input  logic [3:0] hex,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/multi_digit_led_driver.sv
// Time-multiplexed common-anode driver: prescaled scan with blanking
// steps and frame-coherent snapshots of the per-digit inputs.
module multi_digit_led_driver
    import led_pkg::*;
#(
    parameter int NUM_DIGITS  = 4,
    parameter int PRESCALE    = 16,
    parameter int BLANK_STEPS = 3
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    input  logic                    load,
    output logic                    load_ack,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              seg,
    output logic                    dp
);

    localparam int SLOT = BLANK_STEPS + 1;
    localparam int PW   = cnt_width(PRESCALE);
    localparam int SW   = cnt_width(SLOT);
    localparam int DW   = cnt_width(NUM_DIGITS);

    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [SW-1:0] SUB_LAST = SW'(SLOT - 1);
    localparam logic [DW-1:0] DIG_LAST = DW'(NUM_DIGITS - 1);

    logic [PW-1:0]           pre;
    logic [SW-1:0]           sub;
    logic [DW-1:0]           slot;
    logic                    load_pending;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_en;

    logic                  tick;
    logic                  frame_pos0;
    logic                  capture;
    logic [DW-1:0]         sel;
    logic [3:0]            nibble;
    logic                  sel_dp;
    logic [NUM_DIGITS-1:0] lit;
    logic [6:0]            dec_seg;

    // Step position is kept as (slot, sub) so no divider is needed.
    assign tick       = (pre == PRE_LAST);
    assign frame_pos0 = tick && (sub == '0) && (slot == '0);
    assign capture    = frame_pos0 && (load_pending || load);
    assign sel        = DIG_LAST - slot;

    // On a capture tick the segment load must see the fresh inputs.
    always_comb begin
        nibble = 4'h0;
        sel_dp = 1'b0;
        lit    = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (sel == DW'(k)) begin
                nibble = capture ? digits[4*k +: 4]
                                 : shadow_digits[4*k +: 4];
                sel_dp = capture ? dp_in[k] : shadow_dp[k];
                lit[k] = shadow_en[k];
            end
        end
    end

    led_hex_decoder u_dec (
        .hex (nibble),
        .seg (dec_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre           <= '0;
            sub           <= '0;
            slot          <= '0;
            load_pending  <= 1'b1;
            shadow_digits <= '0;
            shadow_dp     <= '0;
            shadow_en     <= '0;
            load_ack      <= 1'b0;
            frame_start   <= 1'b0;
            an            <= '1;
            seg           <= SEG_BLANK;
            dp            <= 1'b1;
        end else begin
            load_ack    <= capture;
            frame_start <= frame_pos0;
            pre         <= tick ? '0 : pre + 1'b1;
            if (capture) begin
                shadow_digits <= digits;
                shadow_dp     <= dp_in;
                shadow_en     <= digit_en;
                load_pending  <= 1'b0;
            end else if (load) begin
                load_pending <= 1'b1;
            end
            if (tick) begin
                if (sub == SUB_LAST) begin
                    sub  <= '0;
                    slot <= (slot == DIG_LAST) ? '0 : slot + 1'b1;
                end else begin
                    sub <= sub + 1'b1;
                end
                unique case (1'b1)
                    (sub == SW'(0)): begin
                        seg <= dec_seg;
                        dp  <= ~sel_dp;
                        an  <= '1;
                    end
                    (sub == SW'(1)): an <= ~lit;
                    (sub == SW'(2)): an <= '1;
                    default: ;
                endcase
            end
        end
    end

endmodule
